fifo_rd_wptr_sync: RTL

Read-clock-domain front end for the async FIFO. It is the producer side of the reader's rq2_wptr input.
- Synchronizes the write-domain Gray write pointer into rclk and drives it to the read-pointer block.
- Decodes the synchronized pointer to binary and computes registered read-side occupancy against the reader's binary rptr.
- Generates data-available and almost-empty status for the consumer.

---
 rtl/fifo_pkg.sv | 23 ++
 rtl/fifo_gray_sync.sv | 29 ++
 rtl/fifo_rd_wptr_sync.sv | 79 +++++++
 3 files changed

// File: rtl/fifo_pkg.sv
// Shared async-FIFO definitions: pointer width, Gray decode, synchronizer depth limits.
package fifo_pkg;

  localparam int unsigned SYNC_STAGES_MIN = 2;
  localparam int unsigned SYNC_STAGES_MAX = 4;
  localparam int unsigned GRAY_MAX_W      = 32;

  // Pointers carry one extra wrap bit above the address.
  function automatic int unsigned ptr_w(input int unsigned addr_w);
    return addr_w + 1;
  endfunction

  // Zero-extended inputs decode correctly: the leading zeros keep the XOR chain at zero.
  function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] g);
    logic [GRAY_MAX_W-1:0] b;
    b[GRAY_MAX_W-1] = g[GRAY_MAX_W-1];
    for (int i = GRAY_MAX_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/fifo_gray_sync.sv
// Multi-flop shift-chain synchronizer for Gray-coded pointers crossing clock domains.
module fifo_gray_sync #(
  parameter int unsigned Width  = 5,
  parameter int unsigned Stages = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [Width-1:0] din,
  output logic [Width-1:0] dout
);

  logic [Width-1:0] sync_q [Stages];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < Stages; k++) begin
        sync_q[k] <= '0;
      end
    end else begin
      sync_q[0] <= din;
      for (int k = 1; k < Stages; k++) begin
        sync_q[k] <= sync_q[k-1];
      end
    end
  end

  assign dout = sync_q[Stages-1];

endmodule

// File: rtl/fifo_rd_wptr_sync.sv
// Read-domain write-pointer sync, occupancy and status. Define RD_UNDERFLOW_DET_EN to add
// the sticky underflow detector (runderflow / runderflow_clr).
module fifo_rd_wptr_sync
  import fifo_pkg::*;
#(
  parameter int unsigned number_of_bit_address = 4,
  parameter int unsigned SYNC_STAGES           = 2,
  parameter int unsigned AE_THRESH             = 2
) (
  input  logic                           rclk,
  input  logic                           rrst_n,
  input  logic [number_of_bit_address:0] wptr_gray,
  input  logic [number_of_bit_address:0] rptr,
  input  logic                           rinc,
  input  logic                           rempty,
  output logic [number_of_bit_address:0] rq2_wptr,
  output logic [number_of_bit_address:0] rlevel,
  output logic                           rdata_avail,
  output logic                           ralmost_empty
`ifdef RD_UNDERFLOW_DET_EN
  ,
  input  logic                           runderflow_clr,
  output logic                           runderflow
`endif
);

  localparam int unsigned PtrW = ptr_w(number_of_bit_address);
  // Out-of-range depths are clamped rather than producing a broken chain.
  localparam int unsigned SyncStages =
      (SYNC_STAGES < SYNC_STAGES_MIN) ? SYNC_STAGES_MIN :
      (SYNC_STAGES > SYNC_STAGES_MAX) ? SYNC_STAGES_MAX : SYNC_STAGES;
  localparam logic [PtrW-1:0] AeThresh = PtrW'(AE_THRESH);

  logic [PtrW-1:0] wbin;
  logic [PtrW-1:0] level_nxt;

  fifo_gray_sync #(
    .Width  (PtrW),
    .Stages (SyncStages)
  ) u_wptr_sync (
    .clk   (rclk),
    .rst_n (rrst_n),
    .din   (wptr_gray),
    .dout  (rq2_wptr)
  );

  assign wbin      = PtrW'(gray2bin(GRAY_MAX_W'(rq2_wptr)));
  // Modular subtraction absorbs pointer wrap; full reads as exactly 2^addr.
  assign level_nxt = wbin - rptr;

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      rlevel        <= '0;
      rdata_avail   <= 1'b0;
      ralmost_empty <= 1'b1;
    end else begin
      rlevel        <= level_nxt;
      rdata_avail   <= (level_nxt != '0);
      ralmost_empty <= (level_nxt <= AeThresh);
    end
  end

`ifdef RD_UNDERFLOW_DET_EN
  // A fresh underflow takes priority over a clear in the same cycle.
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      runderflow <= 1'b0;
    end else if (rinc && rempty) begin
      runderflow <= 1'b1;
    end else if (runderflow_clr) begin
      runderflow <= 1'b0;
    end
  end
`else
  logic unused_rd;
  assign unused_rd = rinc ^ rempty;
`endif

endmodule
